// File: rtl/scrambler_pkg.sv
// Shared definitions for the byte-wide additive scrambler pair.
// The transmit scrambler and the receive descrambler both use lfsr_step,
// so the two ends always generate the same keystream.
package scrambler_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        LOCKED = 2'd1,
        CHECK  = 2'd2
    } rx_state_e;

    localparam logic [7:0] SYNC_WORD_DEF = 8'hA5;
    localparam logic [7:0] LFSR_SEED_DEF = 8'hC5;

    // One LFSR advance: feedback from taps 6 and 3 shifts in at the MSB.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6] ^ s[3], s[7:1]};
    endfunction

endpackage

// File: rtl/descrambler_lfsr.sv
// Keystream generator for the descrambler: an 8-bit LFSR that can be
// reseeded and advanced. keystream_o is the value the register will hold
// after the next advance, which is the byte XORed into the current payload.
module descrambler_lfsr
    import scrambler_pkg::*;
#(
    parameter logic [7:0] SEED = LFSR_SEED_DEF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic       step_i,
    output logic [7:0] keystream_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    assign keystream_o = lfsr_step(lfsr_q);

    // Next-state select: reseed has priority over advance.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = SEED;
        end else if (step_i) begin
            lfsr_d = keystream_o;
        end
    end

    // State register, back to the seed on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/descrambler_rx.sv
// Receive-side descrambler. Hunts for an unscrambled sync byte, reseeds the
// keystream LFSR on every sync, and descrambles FRAME_LEN payload bytes per
// frame. Valid/ready handshakes on both sides with a single output register.
// Optional build macro DESCR_ERR_CNT_EN adds a saturating sync-error counter
// (err_cnt) with a synchronous clear input (err_clr).
//
// state  | meaning
// HUNT   | searching for SYNC_WORD, accepted bytes are discarded
// LOCKED | descrambling payload bytes, cnt = payload index
// CHECK  | frame done, next byte must be SYNC_WORD
module descrambler_rx
    import scrambler_pkg::*;
#(
    parameter int         FRAME_LEN = 16,
    parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEF,
    parameter logic [7:0] LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [7:0]  dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        sof,
    output logic        locked,
`ifdef DESCR_ERR_CNT_EN
    input  logic        err_clr,
    output logic [15:0] err_cnt,
`endif
    output logic        sync_err
);

    localparam logic [7:0] FRAME_LAST = 8'(FRAME_LEN - 1);

    rx_state_e  state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] dout_q, dout_d;
    logic       dout_valid_q, dout_valid_d;
    logic       sof_q, sof_d;
    logic       locked_q, locked_d;
    logic       sync_err_q, sync_err_d;

    logic       in_xfer;
    logic       lfsr_load;
    logic       lfsr_adv;
    logic [7:0] keystream;

    // The output register frees up in the same cycle it is drained, so
    // back-to-back transfers need no bubble.
    assign din_ready = !dout_valid_q || dout_ready;
    assign in_xfer   = din_valid && din_ready;

    descrambler_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .load_i      (lfsr_load),
        .step_i      (lfsr_adv),
        .keystream_o (keystream)
    );

    // Frame FSM, payload counter and output-register next state.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        sof_d        = sof_q;
        sync_err_d   = 1'b0;
        lfsr_load    = 1'b0;
        lfsr_adv     = 1'b0;

        if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
            sof_d        = 1'b0;
        end

        if (in_xfer) begin
            case (state_q)
                HUNT: begin
                    if (din == SYNC_WORD) begin
                        lfsr_load = 1'b1;
                        cnt_d     = 8'd0;
                        state_d   = LOCKED;
                    end
                end
                LOCKED: begin
                    lfsr_adv     = 1'b1;
                    dout_d       = din ^ keystream;
                    dout_valid_d = 1'b1;
                    sof_d        = (cnt_q == 8'd0);
                    if (cnt_q == FRAME_LAST) begin
                        cnt_d   = 8'd0;
                        state_d = CHECK;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                CHECK: begin
                    // A bad marker is dropped here, not re-examined in HUNT.
                    if (din == SYNC_WORD) begin
                        lfsr_load = 1'b1;
                        cnt_d     = 8'd0;
                        state_d   = LOCKED;
                    end else begin
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end

        locked_d = (state_d != HUNT);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            cnt_q        <= 8'd0;
            dout_q       <= 8'd0;
            dout_valid_q <= 1'b0;
            sof_q        <= 1'b0;
            locked_q     <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sof_q        <= sof_d;
            locked_q     <= locked_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign sof        = sof_q;
    assign locked     = locked_q;
    assign sync_err   = sync_err_q;

`ifdef DESCR_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    // Saturating count of sync errors; a clear in the same cycle wins.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = 16'd0;
        end else if (sync_err_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 16'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_descrambler_rx.sv
// Directed bench for descrambler_rx with FRAME_LEN = 2.
// Keystream after seed C5: E2, F1, F8, ...
module tb_descrambler_rx;

    logic        clk;
    logic        rst_n;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        sof;
    logic        locked;
    logic        sync_err;
`ifdef DESCR_ERR_CNT_EN
    logic        err_clr;
    logic [15:0] err_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    descrambler_rx #(
        .FRAME_LEN (2),
        .SYNC_WORD (8'hA5),
        .LFSR_SEED (8'hC5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .sof        (sof),
        .locked     (locked),
`ifdef DESCR_ERR_CNT_EN
        .err_clr    (err_clr),
        .err_cnt    (err_cnt),
`endif
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge, sample just after the rising edge.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        @(negedge clk);
        din_valid  = v;
        din        = d;
        dout_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] d, input logic s);
        chk({tag, ".valid"}, 32'(dout_valid), 32'd1);
        chk({tag, ".dout"},  32'(dout), 32'(d));
        chk({tag, ".sof"},   32'(sof), 32'(s));
    endtask

    initial begin
        rst_n      = 1'b0;
        din        = 8'h00;
        din_valid  = 1'b0;
        dout_ready = 1'b1;
`ifdef DESCR_ERR_CNT_EN
        err_clr    = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst.dout_valid", 32'(dout_valid), 32'd0);
        chk("rst.din_ready",  32'(din_ready),  32'd1);
        chk("rst.locked",     32'(locked),     32'd0);
        chk("rst.sof",        32'(sof),        32'd0);
        chk("rst.sync_err",   32'(sync_err),   32'd0);
        chk("rst.dout",       32'(dout),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Hunt: non-sync bytes are discarded.
        step(1'b1, 8'h00, 1'b1);
        chk("hunt0.valid", 32'(dout_valid), 32'd0);
        chk("hunt0.locked", 32'(locked), 32'd0);
        step(1'b1, 8'h13, 1'b1);
        chk("hunt1.valid", 32'(dout_valid), 32'd0);
        step(1'b1, 8'h7F, 1'b1);
        chk("hunt2.valid", 32'(dout_valid), 32'd0);
        chk("hunt2.locked", 32'(locked), 32'd0);
        step(1'b1, 8'hA5, 1'b1);
        chk("sync.locked", 32'(locked), 32'd1);
        chk("sync.valid", 32'(dout_valid), 32'd0);

        // First frame: keystream E2, F1.
        step(1'b1, 8'hE2, 1'b1);
        expect_out("f1b0", 8'h00, 1'b1);
        step(1'b1, 8'hF1, 1'b1);
        expect_out("f1b1", 8'h00, 1'b0);
        chk("f1b1.locked", 32'(locked), 32'd1);

        // Back-to-back frame with non-zero data.
        step(1'b1, 8'hA5, 1'b1);
        chk("resync.valid", 32'(dout_valid), 32'd0);
        chk("resync.locked", 32'(locked), 32'd1);
        chk("resync.sync_err", 32'(sync_err), 32'd0);
        step(1'b1, 8'h00, 1'b1);
        expect_out("f2b0", 8'hE2, 1'b1);
        step(1'b1, 8'hFF, 1'b1);
        expect_out("f2b1", 8'h0E, 1'b0);

        // Missing sync.
        step(1'b1, 8'h3C, 1'b1);
        chk("miss.sync_err", 32'(sync_err), 32'd1);
        chk("miss.locked", 32'(locked), 32'd0);
        chk("miss.valid", 32'(dout_valid), 32'd0);
        step(1'b0, 8'h00, 1'b1);
        chk("miss.pulse_end", 32'(sync_err), 32'd0);
        step(1'b1, 8'hA5, 1'b1);
        chk("relock.locked", 32'(locked), 32'd1);
        step(1'b1, 8'hE2, 1'b1);
        expect_out("f3b0", 8'h00, 1'b1);
        // Sync value inside payload is plain data.
        step(1'b1, 8'hA5, 1'b1);
        expect_out("f3b1", 8'h54, 1'b0);
        step(1'b1, 8'hA5, 1'b1);
        chk("f4sync.valid", 32'(dout_valid), 32'd0);
        chk("f4sync.locked", 32'(locked), 32'd1);

        // Backpressure mid-frame.
        step(1'b1, 8'h00, 1'b0);
        expect_out("bp.first", 8'hE2, 1'b1);
        chk("bp.din_ready", 32'(din_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'hFF, 1'b0);
            chk("bp.hold.dout", 32'(dout), 32'hE2);
            chk("bp.hold.valid", 32'(dout_valid), 32'd1);
            chk("bp.hold.sof", 32'(sof), 32'd1);
            chk("bp.hold.din_ready", 32'(din_ready), 32'd0);
        end
        step(1'b1, 8'hFF, 1'b1);
        expect_out("bp.resume", 8'h0E, 1'b0);
        step(1'b1, 8'hA5, 1'b1);
        chk("bp.sync.valid", 32'(dout_valid), 32'd0);
        chk("bp.sync.locked", 32'(locked), 32'd1);

        // Reset mid-frame.
        step(1'b1, 8'h00, 1'b1);
        expect_out("pre_rst", 8'hE2, 1'b1);
        @(negedge clk);
        din_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("midrst.valid", 32'(dout_valid), 32'd0);
        chk("midrst.locked", 32'(locked), 32'd0);
        chk("midrst.sof", 32'(sof), 32'd0);
        chk("midrst.dout", 32'(dout), 32'd0);
        chk("midrst.din_ready", 32'(din_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'hE2, 1'b1);
        chk("postrst.hunt", 32'(dout_valid), 32'd0);
        chk("postrst.locked", 32'(locked), 32'd0);
        step(1'b1, 8'hA5, 1'b1);
        step(1'b1, 8'hE2, 1'b1);
        expect_out("postrst.b0", 8'h00, 1'b1);

`ifdef DESCR_ERR_CNT_EN
        chk("errcnt.rst", 32'(err_cnt), 32'd0);
        step(1'b1, 8'hF1, 1'b1);
        step(1'b1, 8'h3C, 1'b1);
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 8'hA5, 1'b1);
            step(1'b1, 8'hE2, 1'b1);
            step(1'b1, 8'hF1, 1'b1);
            step(1'b1, 8'h3C, 1'b1);
        end
        chk("errcnt.three", 32'(err_cnt), 32'd3);
        @(negedge clk);
        din_valid = 1'b0;
        err_clr   = 1'b1;
        @(posedge clk);
        #1;
        chk("errcnt.clr", 32'(err_cnt), 32'd0);
        @(negedge clk);
        err_clr = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
